// File: rtl/mult_pkg.sv
// mult_pkg: operand and product widths and types for the shared 16x9
// multiplier. Both the multiplier and the blocks that feed it use these.
package mult_pkg;

  localparam int MD_WD   = 16;            // multiplicand width
  localparam int MR_WD   = 9;             // multiplier width
  localparam int MDMR_WD = MD_WD + MR_WD; // full product width, no truncation

  typedef logic [MD_WD-1:0]   md_t;
  typedef logic [MR_WD-1:0]   mr_t;
  typedef logic [MDMR_WD-1:0] prod_t;

endpackage

// File: rtl/mult_xy.sv
// mult_xy: purely combinational unsigned multiplier.
// Ports:
//   a - multiplicand, MD_WD bits
//   b - multiplier, MR_WD bits
//   o - full-width product a*b, MD_WD+MR_WD bits
module mult_xy #(
  parameter int MD_WD = 16,
  parameter int MR_WD = 9
) (
  input  logic [MD_WD-1:0]       a,
  input  logic [MR_WD-1:0]       b,
  output logic [MD_WD+MR_WD-1:0] o
);

  // Both operands are widened first so the multiply is evaluated at the
  // full product width and the top bits are never lost.
  assign o = (MD_WD + MR_WD)'(a) * (MD_WD + MR_WD)'(b);

endmodule

// File: rtl/rr_arb.sv
// rr_arb: combinational round-robin arbiter. Grants the first asserted request
// found when searching ptr, ptr+1, ... wrapping modulo N. The pointer register
// is owned by the caller.
// Ports:
//   req    - request vector, N bits
//   ptr    - index at which the search starts (must be < N)
//   gnt    - one-hot grant, zero when no request is asserted
//   gnt_id - encoded index of the granted request (0 when none)
module rr_arb #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id
);

  logic found;

  // Index reached k steps past p, wrapping at N. p < N and k < N, so a single
  // subtraction is enough and no divider is needed.
  function automatic int wrap_idx(int p, int k);
    int s;
    s = p + k;
    return (s >= N) ? s - N : s;
  endfunction

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[wrap_idx(int'(ptr), k)]) begin
        found                        = 1'b1;
        gnt[wrap_idx(int'(ptr), k)]  = 1'b1;
        gnt_id                       = W'(wrap_idx(int'(ptr), k));
      end
    end
  end

endmodule

// File: rtl/mult_rr_sched.sv
// mult_rr_sched: shares one combinational mult_xy among NREQ requesters.
// A round-robin arbiter picks one requester per cycle; its operands are
// registered (S1), multiplied, and the product is registered (S2) together
// with the requester index. Two-cycle latency, one product per cycle.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   req_vld - per-requester request valid
//   req_rdy - per-requester accept, one-hot or zero
//   req_a   - per-requester multiplicand
//   req_b   - per-requester multiplier
//   rsp_vld - product valid
//   rsp_rdy - consumer accepts product
//   rsp_o   - unsigned product A*B, full width
//   rsp_id  - index of the requester the product belongs to
//   busy    - S1 or S2 holds a valid entry
module mult_rr_sched
  import mult_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int ID_WD = $clog2(NREQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_vld,
  output logic [NREQ-1:0]             req_rdy,
  input  logic [NREQ-1:0][MD_WD-1:0]  req_a,
  input  logic [NREQ-1:0][MR_WD-1:0]  req_b,
  output logic                        rsp_vld,
  input  logic                        rsp_rdy,
  output logic [MDMR_WD-1:0]          rsp_o,
  output logic [ID_WD-1:0]            rsp_id,
  output logic                        busy
);

  // Arbitration
  logic [ID_WD-1:0] ptr;
  logic [NREQ-1:0]  gnt;
  logic [ID_WD-1:0] gnt_id;
  logic             xfer;

  // S1 operand register
  logic             s1_vld;
  md_t              s1_a;
  mr_t              s1_b;
  logic [ID_WD-1:0] s1_id;

  // S2 result register
  logic             s2_vld;
  prod_t            s2_o;
  logic [ID_WD-1:0] s2_id;

  prod_t            prod;
  logic             s1_adv;
  logic             s2_adv;

  // A stage may take new data when it is empty or its content moves on this
  // cycle. This chain is what makes rsp_rdy reach req_rdy combinationally.
  assign s2_adv = !s2_vld || rsp_rdy;
  assign s1_adv = !s1_vld || s2_adv;

  rr_arb #(
    .N (NREQ),
    .W (ID_WD)
  ) u_arb (
    .req    (req_vld),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_rdy = (s1_adv && !rst) ? gnt : '0;
  // A grant is only ever raised for an asserted req_vld, so any ready bit
  // marks a completed handshake.
  assign xfer    = |req_rdy;

  // Control state: valid bit of S1 and the round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    if (rst) begin
      s1_vld <= 1'b0;
      ptr    <= '0;
    end else begin
      if (s1_adv) s1_vld <= xfer;
      // Next search starts just past the winner, so it becomes lowest priority.
      if (xfer) ptr <= (gnt_id == ID_WD'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // NOTE: the S1 operand registers are qualified by s1_vld and are never read
  // while it is low, so they carry no reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      s1_a  <= req_a[gnt_id];
      s1_b  <= req_b[gnt_id];
      s1_id <= gnt_id;
    end
  end

  mult_xy #(
    .MD_WD (MD_WD),
    .MR_WD (MR_WD)
  ) u_mult (
    .a (s1_a),
    .b (s1_b),
    .o (prod)
  );

  // S2 drives the response outputs directly, so rsp_o has no path from
  // rsp_rdy. Data is only loaded alongside a valid entry, which keeps a held
  // response stable and leaves the outputs at zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld <= 1'b0;
      s2_o   <= '0;
      s2_id  <= '0;
    end else if (s2_adv) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_o  <= prod;
        s2_id <= s1_id;
      end
    end
  end

  assign rsp_vld = s2_vld;
  assign rsp_o   = s2_o;
  assign rsp_id  = s2_id;
  assign busy    = s1_vld | s2_vld;

endmodule
